// File: rtl/adc_pkg.sv
// Shared constants, state encoding and address helper for the ADC scan/average block.
// The low nibble of the ADC address word is the fixed converter control field.
package adc_pkg;

   localparam int         ADC_W    = 12;
   localparam logic [3:0] CTRL_NIB = 4'b0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      ACQ   = 2'd2,
      FLUSH = 2'd3
   } scan_state_e;

   function automatic logic [7:0] mk_addr(input logic [3:0] ch);
      return {ch, CTRL_NIB};
   endfunction

endpackage

// File: rtl/adc_scan_avg_if.sv
// Averaged-sample stream from the scan block to the encoder.
// This is a one-entry valid/ready handshake.
interface adc_scan_avg_if;

   logic [adc_pkg::ADC_W-1:0] sample_data;
   logic [3:0]                sample_ch;
   logic                      sample_valid;
   logic                      sample_ready;

   modport master (output sample_data, sample_ch, sample_valid, input sample_ready);
   modport slave  (input sample_data, sample_ch, sample_valid, output sample_ready);

endinterface

// File: rtl/adc_scan_avg_out_reg.sv
// One-entry output holding register with a sticky overrun flag.
// A load into a full, stalled register is dropped and the held data is kept.
module adc_out_reg
   import adc_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_clr_ovr,
   input  logic             i_load,
   input  logic [ADC_W-1:0] i_data,
   input  logic [3:0]       i_ch,
   adc_scan_avg_if.master   smp,
   output logic             o_overrun
);

   logic             r_valid;
   logic             r_overrun;
   logic [ADC_W-1:0] r_data;
   logic [3:0]       r_ch;
   logic             w_block;

   assign w_block = r_valid & ~smp.sample_ready;

   // A load has priority over a same-cycle accept, so valid stays set.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ch    <= '0;
      end else if (i_clr) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_ch    <= '0;
      end else if (i_load && !w_block) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_ch    <= i_ch;
      end else if (r_valid && smp.sample_ready) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_overrun <= 1'b0;
      else if (i_clr_ovr)
         r_overrun <= 1'b0;
      else if (i_load && w_block)
         r_overrun <= 1'b1;
   end

   assign smp.sample_valid = r_valid;
   assign smp.sample_data  = r_data;
   assign smp.sample_ch    = r_ch;
   assign o_overrun        = r_overrun;

endmodule

// File: rtl/adc_scan_avg.sv
// Channel sweep with per-channel averaging behind a one-frame-lag serial ADC.
//   state | meaning
//   IDLE  | stopped; waits for a run rising edge
//   PRIME | first frame sent; its stale result is discarded
//   ACQ   | each result is accumulated and the address advances
//   FLUSH | last address sent; one more result completes the final channel
module adc_scan_avg
   import adc_pkg::*;
#(
   parameter int NUM_CH   = 11,
   parameter int AVG_LOG2 = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_key_state,
   input  logic             i_en_adc,
   input  logic             i_continuous,
   input  logic [ADC_W-1:0] i_adc_out,
   input  logic             i_adc_state,
   output logic [7:0]       o_din_address,
   adc_scan_avg_if.master   smp,
   output logic             o_sweep_done,
   output logic             o_overrun
);

   localparam int               SMP_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int               ACC_W    = ADC_W + AVG_LOG2;
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
   localparam logic [3:0]       CH_LAST  = 4'(NUM_CH - 1);

   scan_state_e      r_state, w_state_nxt;
   logic             r_run_q, r_adc_state_q, r_cap, r_sweep_done;
   logic [3:0]       r_a_ch, r_r_ch, w_a_ch_nxt;
   logic [SMP_W-1:0] r_a_smp, r_r_smp, w_a_smp_nxt;
   logic [ACC_W-1:0] r_acc, w_sum;
   logic             w_run, w_run_rise, w_rise, w_a_wrap;
   logic             w_take, w_advance, w_load;

   assign w_run      = i_key_state & i_en_adc;
   assign w_run_rise = w_run & ~r_run_q;
   assign w_rise     = i_adc_state & ~r_adc_state_q;
   assign w_sum      = r_acc + ACC_W'(i_adc_out);
   assign w_a_wrap   = (r_a_smp == SMP_LAST) && (r_a_ch == CH_LAST);
   assign w_load     = w_take && (r_r_smp == SMP_LAST);

   always_comb begin
      w_a_smp_nxt = r_a_smp + SMP_W'(1);
      w_a_ch_nxt  = r_a_ch;
      if (r_a_smp == SMP_LAST) begin
         w_a_smp_nxt = '0;
         w_a_ch_nxt  = (r_a_ch == CH_LAST) ? 4'd0 : r_a_ch + 4'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // In continuous mode the next sweep's first address rides on the flush frame.
   always_comb begin
      w_state_nxt = r_state;
      w_take      = 1'b0;
      w_advance   = 1'b0;
      if (!w_run) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:  if (w_run_rise) w_state_nxt = PRIME;
            PRIME: if (r_cap) begin
                      w_advance   = 1'b1;
                      w_state_nxt = ACQ;
                   end
            ACQ:   if (r_cap) begin
                      w_take    = 1'b1;
                      w_advance = 1'b1;
                      if (w_a_wrap && !i_continuous) w_state_nxt = FLUSH;
                   end
            FLUSH: if (r_cap) begin
                      w_take      = 1'b1;
                      w_state_nxt = IDLE;
                   end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_run_q       <= 1'b0;
         r_adc_state_q <= 1'b0;
         r_cap         <= 1'b0;
         r_sweep_done  <= 1'b0;
         r_a_ch        <= '0;
         r_a_smp       <= '0;
         r_r_ch        <= '0;
         r_r_smp       <= '0;
         r_acc         <= '0;
      end else begin
         r_run_q       <= w_run;
         r_adc_state_q <= i_adc_state;
         r_cap         <= w_rise;
         r_sweep_done  <= w_load && (r_r_ch == CH_LAST);
         if (!w_run || w_run_rise) begin
            r_a_ch  <= '0;
            r_a_smp <= '0;
            r_r_ch  <= '0;
            r_r_smp <= '0;
            r_acc   <= '0;
         end else begin
            if (w_advance) begin
               r_r_ch  <= r_a_ch;
               r_r_smp <= r_a_smp;
               r_a_ch  <= w_a_ch_nxt;
               r_a_smp <= w_a_smp_nxt;
            end
            if (w_take)
               r_acc <= w_load ? '0 : w_sum;
         end
      end
   end

   adc_out_reg u_out_reg (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (~w_run),
      .i_clr_ovr (w_run_rise),
      .i_load    (w_load),
      .i_data    (w_sum[ACC_W-1 -: ADC_W]),
      .i_ch      (r_r_ch),
      .smp       (smp),
      .o_overrun (o_overrun)
   );

   assign o_din_address = mk_addr(r_a_ch);
   assign o_sweep_done  = r_sweep_done;

endmodule

// File: tb/tb_adc_scan_avg.sv
// Directed bench for adc_scan_avg: three configurations behind one lagging ADC model,
// with expected averages queued at stimulus time and popped on each accepted output.
module tb_adc_scan_avg;

   typedef struct {
      logic [3:0]  ch;
      logic [11:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key = 1'b0;
   logic        cont = 1'b0;
   logic        adc_state = 1'b0;
   logic        ready = 1'b1;
   logic [11:0] adc_out = 12'h000;
   logic [2:0]  en = 3'b000;
   logic [1:0]  sel = 2'd0;

   logic [7:0]  addr_a, addr_b, addr_c;
   logic        sd_a, sd_b, sd_c, ov_a, ov_b, ov_c;

   logic        m_valid, m_sd, m_ov;
   logic [11:0] m_data;
   logic [3:0]  m_ch;
   logic [7:0]  m_addr;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_tests = 0;
   int          n_fail = 0;
   int          sd_cnt = 0;
   int          exp_sd = 0;
   logic        exp_ovr = 1'b0;
   logic        held = 1'b0;

   always #5 clk = ~clk;

   adc_scan_avg_if if_a ();
   adc_scan_avg_if if_b ();
   adc_scan_avg_if if_c ();
   assign if_a.sample_ready = ready;
   assign if_b.sample_ready = ready;
   assign if_c.sample_ready = ready;

   adc_scan_avg #(.NUM_CH(3), .AVG_LOG2(2)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_key_state(key), .i_en_adc(en[0]),
      .i_continuous(cont), .i_adc_out(adc_out), .i_adc_state(adc_state),
      .o_din_address(addr_a), .smp(if_a), .o_sweep_done(sd_a), .o_overrun(ov_a));

   adc_scan_avg #(.NUM_CH(2), .AVG_LOG2(4)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_key_state(key), .i_en_adc(en[1]),
      .i_continuous(cont), .i_adc_out(adc_out), .i_adc_state(adc_state),
      .o_din_address(addr_b), .smp(if_b), .o_sweep_done(sd_b), .o_overrun(ov_b));

   adc_scan_avg #(.NUM_CH(2), .AVG_LOG2(0)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_key_state(key), .i_en_adc(en[2]),
      .i_continuous(cont), .i_adc_out(adc_out), .i_adc_state(adc_state),
      .o_din_address(addr_c), .smp(if_c), .o_sweep_done(sd_c), .o_overrun(ov_c));

   always_comb begin
      m_valid = if_a.sample_valid;
      m_data  = if_a.sample_data;
      m_ch    = if_a.sample_ch;
      m_sd    = sd_a;
      m_ov    = ov_a;
      m_addr  = addr_a;
      if (sel == 2'd1) begin
         m_valid = if_b.sample_valid;
         m_data  = if_b.sample_data;
         m_ch    = if_b.sample_ch;
         m_sd    = sd_b;
         m_ov    = ov_b;
         m_addr  = addr_b;
      end else if (sel == 2'd2) begin
         m_valid = if_c.sample_valid;
         m_data  = if_c.sample_data;
         m_ch    = if_c.sample_ch;
         m_sd    = sd_c;
         m_ov    = ov_c;
         m_addr  = addr_c;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_sd) sd_cnt++;
      if (m_valid && ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {16'd0, m_ch, m_data}, 32'hFFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            chk("out_ch", {28'd0, m_ch}, {28'd0, mon_e.ch});
            chk("out_data", {20'd0, m_data}, {20'd0, mon_e.data});
         end
      end
   end

   // One conversion frame; adc_out carries junk until one cycle after the rise.
   task automatic frame(input logic [11:0] v);
      adc_state = 1'b1;
      adc_out   = 12'h5A5;
      @(negedge clk);
      adc_out   = v;
      @(negedge clk);
      @(negedge clk);
      adc_state = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic start_run();
      @(negedge clk);
      en = 3'b000;
      @(negedge clk);
      en[sel] = 1'b1;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic run_seq(input int nch, input int alog2, input int n_frames, input bit all_max);
      int ns;
      int n;
      int acc;
      ns  = 1 << alog2;
      n   = nch * ns;
      acc = 0;
      for (int j = 0; j < n_frames; j++) begin
         int          ch_a, s, sch, ssmp, sweep;
         logic [11:0] val;
         exp_t        e;
         ch_a = cont ? ((j % n) / ns) : ((j < n) ? (j / ns) : 0);
         chk("din_address", {24'd0, m_addr}, {24'd0, ch_a[3:0], 4'b0000});
         if (j == 0) begin
            val = 12'hFFF;
         end else begin
            s     = j - 1;
            sweep = s / n;
            sch   = (s % n) / ns;
            ssmp  = s % ns;
            val   = all_max ? 12'hFFF : 12'(100 * sch + ssmp + sweep);
            acc  += int'(val);
            if (ssmp == ns - 1) begin
               e.ch   = sch[3:0];
               e.data = 12'(acc >> alog2);
               acc    = 0;
               if (sch == nch - 1) exp_sd++;
               if (!ready && held) begin
                  exp_ovr = 1'b1;
               end else begin
                  sb.push_back(e);
                  held = !ready;
               end
            end
         end
         frame(val);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_din_address", {24'd0, m_addr}, 32'h00);
      chk("rst_sample_data", {20'd0, m_data}, 32'h0);
      chk("rst_sample_ch", {28'd0, m_ch}, 32'h0);
      chk("rst_sample_valid", {31'd0, m_valid}, 32'h0);
      chk("rst_sweep_done", {31'd0, m_sd}, 32'h0);
      chk("rst_overrun", {31'd0, m_ov}, 32'h0);

      // single sweep, NUM_CH=3, AVG_LOG2=2
      key = 1'b1;
      start_run();
      run_seq(3, 2, 13, 1'b0);
      chk("sweep1_din_idle", {24'd0, m_addr}, 32'h00);
      frame(12'h123);
      chk("sweep1_sb_empty", sb.size(), 0);
      chk("sweep1_sweep_done", sd_cnt, exp_sd);

      // ready held low: ch0 kept, later channels dropped
      @(posedge clk); #1 ready = 1'b0;
      start_run();
      run_seq(3, 2, 13, 1'b0);
      chk("stall_valid", {31'd0, m_valid}, 32'h1);
      chk("stall_data", {20'd0, m_data}, 32'd1);
      chk("stall_ch", {28'd0, m_ch}, 32'd0);
      chk("stall_overrun", {31'd0, m_ov}, {31'd0, exp_ovr});
      chk("stall_sweep_done", sd_cnt, exp_sd);
      @(posedge clk); #1 ready = 1'b1;
      held = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("stall_valid_cleared", {31'd0, m_valid}, 32'h0);
      chk("stall_sb_empty", sb.size(), 0);

      // run loss mid-sweep, then a clean restart
      @(posedge clk); #1 ready = 1'b0;
      start_run();
      chk("restart_overrun_clr", {31'd0, m_ov}, 32'h0);
      exp_ovr = 1'b0;
      run_seq(3, 2, 6, 1'b0);
      chk("drop_valid_before", {31'd0, m_valid}, 32'h1);
      chk("drop_sb_pending", sb.size(), 1);
      en = 3'b000;
      @(negedge clk);
      chk("drop_valid_now", {31'd0, m_valid}, 32'h0);
      chk("drop_data_clr", {20'd0, m_data}, 32'h0);
      chk("drop_din_address", {24'd0, m_addr}, 32'h00);
      sb.delete();
      held = 1'b0;
      @(posedge clk); #1 ready = 1'b1;
      start_run();
      run_seq(3, 2, 13, 1'b0);
      chk("resweep_sb_empty", sb.size(), 0);
      chk("resweep_sweep_done", sd_cnt, exp_sd);

      // full-scale samples with 16-sample averaging
      en = 3'b000;
      @(posedge clk); #1 sel = 2'd1;
      start_run();
      run_seq(2, 4, 33, 1'b1);
      chk("fullscale_sb_empty", sb.size(), 0);
      chk("fullscale_overrun", {31'd0, m_ov}, 32'h0);
      chk("fullscale_sweep_done", sd_cnt, exp_sd);

      // continuous sweeps, NUM_CH=2, AVG_LOG2=0
      en = 3'b000;
      @(posedge clk); #1 sel = 2'd2;
      cont = 1'b1;
      start_run();
      run_seq(2, 0, 7, 1'b0);
      chk("cont_sb_empty", sb.size(), 0);
      chk("cont_sweep_done", sd_cnt, exp_sd);
      en = 3'b000;
      @(negedge clk);
      @(negedge clk);
      chk("cont_stop_valid", {31'd0, m_valid}, 32'h0);
      chk("cont_stop_din", {24'd0, m_addr}, 32'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
